// File: rtl/bit_serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM encoding and counter sizing.
package bit_serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_sub_full_sub_cell.sv
// One-bit full subtractor: diff = x - y - bin, bout = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_sub.sv
// LSB-first serial subtractor d = a - b, one bit per clock, start/busy/done.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_sub
  import bit_serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             dbit;
  logic             bout;
  logic             load;
  logic             step;
  logic             last;

  assign load = start && (state != ST_SHIFT);
  assign step = (state == ST_SHIFT);
  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  full_sub_cell u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (br),
    .diff (dbit),
    .bout (bout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Difference bits enter at the MSB so bit 0 ends up in d[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res  <= {dbit, res[WIDTH-1:1]};
      br   <= bout;
      cnt  <= cnt + 1'b1;
      if (last) begin
        d      <= {dbit, res[WIDTH-1:1]};
        borrow <= bout;
      end
    end
  end

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Last dbit is the result MSB, so overflow is ready on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (step && last) begin
      ovf <= (a_msb ^ b_msb) & (a_msb ^ dbit);
    end
  end
`endif

endmodule
